fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one 16x8 synchronous FIFO write port between `NUM_REQ` producers. It sits directly in front of the FIFO and drives its `w_enable`/`w_data` from the granted producer. It takes the FIFO's `full` as backpressure. Grants are burst-locked, up to `MAX_BURST` accepted beats per tenure, so one producer's data stays contiguous without starving the others.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding
// and the ceiling-log2 helper used to size the index and beat counters.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: scans req starting one past the last
// owner, so the most recent owner is considered last.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // First requester found in rotation order last+1, last+2, ..., last.
  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port between
// NUM_REQ producers. A tenure ends when the owner stops requesting or after
// MAX_BURST accepted beats; the next owner is granted on the same edge.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic                      fifo_full_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic                      w_enable_o,
  output logic [DATA_W-1:0]         w_data_o,
  output logic                      busy_o
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               busy_q, busy_d;

  logic               owner_req;
  logic               accept;
  logic               release_own;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

  // Owner request, write acceptance and end-of-tenure detection.
  assign owner_req   = |(grant_q & req_i);
  assign accept      = owner_req & ~fifo_full_i;
  assign release_own = (state_q == ST_OWN) &&
                       (!owner_req || (accept && (beat_cnt_q == LAST_BEAT)));

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i    (req_i),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  // State register; reset clears the grant at once so no write can issue.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: arbitrate when idle or releasing, else count accepted beats.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    if ((state_q == ST_IDLE) || release_own) begin
      beat_cnt_d = '0;
      if (pick_valid) begin
        state_d = ST_OWN;
        grant_d = pick_onehot;
        last_d  = pick_idx;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    busy_d = (state_d == ST_OWN);
  end

  // Outputs: write strobe, per-producer ack and AND-OR data mux on the grant.
  always_comb begin
    w_enable_o = accept;
    req_ack_o  = grant_q & req_i & {NUM_REQ{~fifo_full_i}};
    w_data_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        w_data_o = w_data_o | req_data_i[i*DATA_W +: DATA_W];
      end else begin
        w_data_o = w_data_o;
      end
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 producers, 8-bit data,
// bursts of 4). Inputs change on the falling edge; outputs are sampled 1
// time unit later.
module tb_fifo_wr_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic [3:0]  req_i;
  logic [31:0] req_data_i;
  logic        fifo_full_i;
  logic [3:0]  grant_o;
  logic [3:0]  req_ack_o;
  logic        w_enable_o;
  logic [7:0]  w_data_o;
  logic        busy_o;

  logic [7:0]  pd [4];
  int          checks;
  int          errors;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .fifo_full_i (fifo_full_i),
    .grant_o     (grant_o),
    .req_ack_o   (req_ack_o),
    .w_enable_o  (w_enable_o),
    .w_data_o    (w_data_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    req_data_i = '0;
    for (int i = 0; i < 4; i++) req_data_i[i*8 +: 8] = pd[i];
  end

  task automatic do_reset();
    reset_i     = 1'b1;
    req_i       = 4'b0000;
    fifo_full_i = 1'b0;
    for (int i = 0; i < 4; i++) pd[i] = 8'h00;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    req_i       = 4'b1111;
    fifo_full_i = 1'b0;
    for (int i = 0; i < 4; i++) pd[i] = 8'hA0 + 8'(i);
    @(negedge clk_i); #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b exp 0000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b exp 0", w_enable_o); end
    checks++; if (req_ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b exp 0000", req_ack_o); end
    checks++; if (w_data_o !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h exp 00", w_data_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    req_i   = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0001;
    pd[0] = 8'h10;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL single_pregrant: got %b exp 0000", grant_o); end
    for (int b = 0; b < 6; b++) begin
      @(negedge clk_i);
      pd[0] = 8'h10 + 8'(b);
      #1;
      checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL single_grant[%0d]: got %b exp 0001", b, grant_o); end
      checks++; if (w_enable_o !== 1'b1) begin errors++; $display("FAIL single_wen[%0d]: got %b exp 1", b, w_enable_o); end
      checks++; if (w_data_o !== 8'h10 + 8'(b)) begin errors++; $display("FAIL single_wdata[%0d]: got %h exp %h", b, w_data_o, 8'h10 + 8'(b)); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy[%0d]: got %b exp 1", b, busy_o); end
      if (b == 4) begin
        checks++; if (dut.beat_cnt_q !== 3'd0) begin errors++; $display("FAIL single_regrant_cnt: got %0d exp 0", dut.beat_cnt_q); end
      end
    end
    @(negedge clk_i);
    req_i = 4'b0000;
    #1;
    checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL single_drop_wen: got %b exp 0", w_enable_o); end
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL single_drop_grant: got %b exp 0001", grant_o); end
    @(negedge clk_i); #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL single_idle_grant: got %b exp 0000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b exp 0", busy_o); end
  endtask

  task automatic test_round_robin();
    int         pc [4];
    int         own;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) pc[i] = 0;
    req_i = 4'b1111;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL rr_pregrant: got %b exp 0000", grant_o); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) pd[i] = 8'((i << 4) | pc[i]);
      #1;
      own   = (k / 4) % 4;
      exp_g = 4'(1 << own);
      exp_d = 8'((own << 4) | pc[own]);
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, grant_o, exp_g); end
      checks++; if (w_enable_o !== 1'b1) begin errors++; $display("FAIL rr_wen[%0d]: got %b exp 1", k, w_enable_o); end
      checks++; if (w_data_o !== exp_d) begin errors++; $display("FAIL rr_wdata[%0d]: got %h exp %h", k, w_data_o, exp_d); end
      checks++; if (req_ack_o !== exp_g) begin errors++; $display("FAIL rr_ack[%0d]: got %b exp %b", k, req_ack_o, exp_g); end
      pc[own] = pc[own] + 1;
    end
    @(negedge clk_i);
    req_i = 4'b0000;
  endtask

  task automatic test_full_stall();
    do_reset();
    req_i = 4'b0010;
    @(negedge clk_i);
    req_i = 4'b0011;
    pd[1] = 8'h20;
    #1;
    checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b exp 0010", grant_o); end
    checks++; if (w_data_o !== 8'h20) begin errors++; $display("FAIL stall_wdata0: got %h exp 20", w_data_o); end
    @(negedge clk_i);
    pd[1] = 8'h21;
    #1;
    checks++; if (w_enable_o !== 1'b1) begin errors++; $display("FAIL stall_wen1: got %b exp 1", w_enable_o); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      fifo_full_i = 1'b1;
      pd[1] = 8'h22;
      #1;
      checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL stall_hold_grant[%0d]: got %b exp 0010", c, grant_o); end
      checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL stall_hold_wen[%0d]: got %b exp 0", c, w_enable_o); end
      checks++; if (req_ack_o !== 4'b0000) begin errors++; $display("FAIL stall_hold_ack[%0d]: got %b exp 0000", c, req_ack_o); end
      checks++; if (dut.beat_cnt_q !== 3'd2) begin errors++; $display("FAIL stall_hold_cnt[%0d]: got %0d exp 2", c, dut.beat_cnt_q); end
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      fifo_full_i = 1'b0;
      pd[1] = 8'h22 + 8'(b);
      #1;
      checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL stall_resume_grant[%0d]: got %b exp 0010", b, grant_o); end
      checks++; if (w_enable_o !== 1'b1) begin errors++; $display("FAIL stall_resume_wen[%0d]: got %b exp 1", b, w_enable_o); end
      checks++; if (w_data_o !== 8'h22 + 8'(b)) begin errors++; $display("FAIL stall_resume_wdata[%0d]: got %h exp %h", b, w_data_o, 8'h22 + 8'(b)); end
    end
    @(negedge clk_i); #1;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL stall_next_grant: got %b exp 0001", grant_o); end
    checks++; if (dut.beat_cnt_q !== 3'd0) begin errors++; $display("FAIL stall_next_cnt: got %0d exp 0", dut.beat_cnt_q); end
    req_i = 4'b0000;
  endtask

  task automatic test_drop();
    do_reset();
    req_i = 4'b0100;
    @(negedge clk_i);
    req_i = 4'b1101;
    pd[2] = 8'h30;
    pd[3] = 8'h40;
    #1;
    checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL drop_grant: got %b exp 0100", grant_o); end
    checks++; if (w_enable_o !== 1'b1) begin errors++; $display("FAIL drop_wen: got %b exp 1", w_enable_o); end
    @(negedge clk_i);
    req_i = 4'b1001;
    #1;
    checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL drop_nowrite_wen: got %b exp 0", w_enable_o); end
    checks++; if (req_ack_o !== 4'b0000) begin errors++; $display("FAIL drop_nowrite_ack: got %b exp 0000", req_ack_o); end
    @(negedge clk_i); #1;
    checks++; if (grant_o !== 4'b1000) begin errors++; $display("FAIL drop_next_grant: got %b exp 1000", grant_o); end
    checks++; if (dut.beat_cnt_q !== 3'd0) begin errors++; $display("FAIL drop_next_cnt: got %0d exp 0", dut.beat_cnt_q); end
    checks++; if (w_data_o !== 8'h40) begin errors++; $display("FAIL drop_next_wdata: got %h exp 40", w_data_o); end
    req_i = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_i = 4'b1000;
    pd[3] = 8'h50;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (w_enable_o !== 1'b1) begin errors++; $display("FAIL areset_pre_wen: got %b exp 1", w_enable_o); end
    #2;
    reset_i = 1'b1;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL areset_grant: got %b exp 0000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b exp 0", busy_o); end
    checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL areset_wen: got %b exp 0", w_enable_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    req_i   = 4'b1111;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL areset_idle: got %b exp 0000", grant_o); end
    @(negedge clk_i); #1;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL areset_first_grant: got %b exp 0001", grant_o); end
    req_i = 4'b0000;
  endtask

  task automatic test_full_from_start();
    do_reset();
    fifo_full_i = 1'b1;
    req_i       = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL full_grant[%0d]: got %b exp 0100", c, grant_o); end
      checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL full_wen[%0d]: got %b exp 0", c, w_enable_o); end
      checks++; if (req_ack_o !== 4'b0000) begin errors++; $display("FAIL full_ack[%0d]: got %b exp 0000", c, req_ack_o); end
    end
    @(negedge clk_i);
    req_i = 4'b0000;
    #1;
    checks++; if (w_enable_o !== 1'b0) begin errors++; $display("FAIL full_drop_wen: got %b exp 0", w_enable_o); end
    @(negedge clk_i); #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL full_idle_grant: got %b exp 0000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_idle_busy: got %b exp 0", busy_o); end
    fifo_full_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_async_reset();
    test_full_from_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
